// File: rtl/port_bus_scheduler.sv
// port_bus_scheduler: round-robin, time-sliced arbiter for the shared portBus/dataBus.
// Every grant is followed by one turnaround cycle, so two cores never drive the bus at once.
module port_bus_scheduler #(
  parameter int N_CORES = 4,
  parameter int Q_W     = 16,
  parameter int ID_W    = 2
) (
  input  logic               fastClk,
  input  logic               rstN,
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] hlt,
  input  logic [N_CORES-1:0] done,
  input  logic [Q_W-1:0]     quantum,
  output logic [N_CORES-1:0] grant,
  output logic [ID_W-1:0]    grantId,
  output logic               busy,
  output logic               preempt,
  output logic [Q_W-1:0]     sliceCnt
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  logic [1:0]         state;
  logic [ID_W-1:0]    ptr, win, idx;
  logic [Q_W-1:0]     q_lat;
  logic [N_CORES-1:0] elig, others;
  logic               found, rel, expire;
  assign elig   = req & ~hlt;
  assign others = elig & ~grant;
  assign rel    = done[grantId] | ~req[grantId] | hlt[grantId];
  assign expire = (q_lat != '0) && (sliceCnt == '0);
  // Scan from the farthest offset down so the one nearest ptr wins last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % N_CORES);
      if (elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  always_ff @(posedge fastClk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      grant    <= '0;
      grantId  <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      sliceCnt <= '0;
      ptr      <= '0;
      q_lat    <= '0;
    end else if (state == GRANT) begin
      if (rel || (expire && others != '0)) begin
        state   <= RELEASE;
        grant   <= '0;
        busy    <= 1'b0;
        preempt <= ~rel;
      end else if (expire) begin
        sliceCnt <= q_lat - 1'b1;
      end else if (q_lat != '0) begin
        sliceCnt <= sliceCnt - 1'b1;
      end
    end else begin
      preempt <= 1'b0;
      if (found) begin
        state    <= GRANT;
        grant    <= {{(N_CORES-1){1'b0}}, 1'b1} << win;
        grantId  <= win;
        busy     <= 1'b1;
        q_lat    <= quantum;
        sliceCnt <= (quantum == '0) ? '0 : quantum - 1'b1;
        ptr      <= ID_W'((int'(win) + 1) % N_CORES);
      end else begin
        state    <= IDLE;
        grantId  <= '0;
        sliceCnt <= '0;
      end
    end
  end
endmodule
